// File: rtl/pkg_bus.sv
// Shared system-bus encodings plus the LLC bus master's state type and op helpers.
package pkg_bus;

  typedef enum logic [2:0] {
    BUS_NOP        = 3'b000,
    BUS_READ       = 3'b001,
    BUS_WRITE      = 3'b010,
    BUS_INVALIDATE = 3'b011,
    BUS_RWIM       = 3'b100
  } bus_operation_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'b00,
    SNOOP_HIT   = 2'b01,
    SNOOP_HITM  = 2'b10
  } snoop_result_e;

  typedef struct packed {
    bus_operation_e operation;
    logic [31:0]    address;
    logic [3:0]     cache_id;
  } bus_msg_st;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SNOOP,
    ST_BACKOFF,
    ST_DONE
  } llc_bus_state_e;

  function automatic logic is_legal_busop(input logic [2:0] op);
    return (op >= 3'b001) && (op <= 3'b100);
  endfunction

  function automatic logic is_read_class(input logic [2:0] op);
    return (op == BUS_READ) || (op == BUS_RWIM);
  endfunction

endpackage

// File: rtl/llc_bus_master_if.sv
// LLC request, system-bus address/snoop and completion signals of the LLC bus master.
interface llc_bus_master_if;
  import pkg_bus::*;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        bus_valid;
  bus_msg_st   bus_msg;
  logic        bus_grant;
  logic [1:0]  snoop_in;
  logic        rsp_valid;
  logic [1:0]  rsp_snoop;
  logic        rsp_err;

  modport master (
    input  req_valid, req_op, req_addr, bus_grant, snoop_in,
    output req_ready, bus_valid, bus_msg, rsp_valid, rsp_snoop, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, bus_grant, snoop_in,
    input  req_ready, bus_valid, bus_msg, rsp_valid, rsp_snoop, rsp_err
  );
endinterface

// File: rtl/llc_bus_master_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/llc_bus_master.sv
// LLC bus master: issues one bus transaction at a time, samples the snoop result,
// retries HITM'd reads after a backoff and counts completed transactions per class.
module llc_bus_master
  import pkg_bus::*;
#(
  parameter int         SNOOP_WAIT = 2,
  parameter int         RETRY_GAP  = 4,
  parameter int         MAX_RETRY  = 3,
  parameter int         CNT_W      = 32,
  parameter logic [3:0] CACHE_ID   = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  llc_bus_master_if.master  llc,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  inv_count
);

  // One timer serves both the snoop wait and the retry backoff.
  localparam int TMAX = (SNOOP_WAIT > RETRY_GAP) ? SNOOP_WAIT : RETRY_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  llc_bus_state_e state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [2:0]     op_q, op_d;
  logic [31:0]    addr_q, addr_d;
  logic [1:0]     snoop_q, snoop_d;
  logic           err_q, err_d;
  bus_msg_st      msg;

  // NOTE: async reset clears every register, so an abandoned transaction leaves
  // no stale op, timer or response behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      snoop_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a hold-value default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    op_d    = op_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (llc.req_valid) begin
          op_d    = llc.req_op;
          addr_d  = llc.req_addr;
          retry_d = '0;
          if (is_legal_busop(llc.req_op)) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            snoop_d = SNOOP_NOHIT;
          end
        end
      end
      ST_ISSUE: begin
        if (llc.bus_grant) begin
          state_d = ST_SNOOP;
          timer_d = TW'(SNOOP_WAIT - 1);
        end
      end
      ST_SNOOP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (is_read_class(op_q) && (llc.snoop_in == SNOOP_HITM)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            timer_d = TW'(RETRY_GAP - 1);
            state_d = ST_BACKOFF;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            snoop_d = SNOOP_HITM;
          end
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          snoop_d = llc.snoop_in;
        end
      end
      ST_BACKOFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign msg = '{operation: bus_operation_e'(op_q), address: addr_q, cache_id: CACHE_ID};

  assign llc.req_ready = (state_q == ST_IDLE);
  assign llc.bus_valid = (state_q == ST_ISSUE);
  assign llc.bus_msg   = (state_q == ST_ISSUE) ? msg : '0;
  assign llc.rsp_valid = (state_q == ST_DONE);
  assign llc.rsp_snoop = snoop_q;
  assign llc.rsp_err   = err_q;

  // Counting happens in DONE only, so a transaction counts once however often it retried.
  logic done_ok;
  assign done_ok = (state_q == ST_DONE) && !err_q;

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_ok && is_read_class(op_q)),
    .count (rd_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_ok && (op_q == BUS_WRITE)),
    .count (wr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_inv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_ok && (op_q == BUS_INVALIDATE)),
    .count (inv_count)
  );

endmodule
